// File: rtl/lpf_ctrl.sv
// Low-pass filter control: CPU shadow registers, serial frame to the
// analog front end, and parallel pd/fc outputs updated after each frame.
module lpf_ctrl #(
    parameter int N_CH     = 2,
    parameter int FC_W     = 8,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 32,
    parameter int SCLK_DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    input  logic [ADDR_W-1:0]    address,
    input  logic [DATA_W-1:0]    wdata,
    input  logic                 wstrb,
    output logic                 ready,
    output logic [DATA_W-1:0]    rdata,
    output logic                 busy,
    output logic [N_CH-1:0]      pd,
    output logic [N_CH*FC_W-1:0] fc,
    output logic                 sclk,
    output logic                 sdata,
    output logic                 sload
);

    localparam int CW = FC_W + 1;
    localparam int L  = N_CH * CW;
    localparam int BW = $clog2(L + 1);
    localparam int DW = $clog2(SCLK_DIV + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t              state_q;
    logic [CW-1:0]       cfg_q [N_CH];
    logic [L-1:0]        snap;
    logic [L-1:0]        sr_q;
    logic [L-1:0]        frm_q;
    logic [BW-1:0]       bit_q;
    logic [DW-1:0]       div_q;
    logic                hi_q;
    logic                pend_q;
    logic                busy_q;
    logic                sclk_q;
    logic                sdata_q;
    logic                sload_q;
    logic [N_CH-1:0]     pd_q;
    logic [N_CH*FC_W-1:0] fc_q;
    logic                ready_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   rdata_d;
    logic                commit;
    logic                last_div;
    logic                go;

    assign commit   = valid && wstrb && (address == ADDR_W'(N_CH)) && wdata[0];
    assign last_div = (div_q == DW'(SCLK_DIV - 1));
    assign go       = (commit || pend_q) &&
                      ((state_q == IDLE) || (state_q == LOAD && last_div));

    // Channel 0 occupies the MSBs so it is shifted out first.
    always_comb begin
        snap = '0;
        for (int i = 0; i < N_CH; i++) begin
            snap[L-1-i*CW -: CW] = cfg_q[i];
        end
    end

    always_comb begin
        rdata_d = '0;
        if (valid && !wstrb) begin
            for (int i = 0; i < N_CH; i++) begin
                if (address == ADDR_W'(i)) rdata_d = DATA_W'(cfg_q[i]);
            end
            if (address == ADDR_W'(N_CH)) rdata_d = DATA_W'({pend_q, busy_q});
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
            for (int i = 0; i < N_CH; i++) cfg_q[i] <= '0;
        end else begin
            ready_q <= valid;
            rdata_q <= rdata_d;
            if (valid && wstrb) begin
                for (int i = 0; i < N_CH; i++) begin
                    if (address == ADDR_W'(i)) cfg_q[i] <= wdata[CW-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            frm_q   <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            hi_q    <= 1'b0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            sclk_q  <= 1'b0;
            sdata_q <= 1'b0;
            sload_q <= 1'b0;
            pd_q    <= '0;
            fc_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: ;
                SHIFT: begin
                    div_q <= div_q + 1'b1;
                    if (last_div) begin
                        div_q <= '0;
                        if (!hi_q) begin
                            hi_q   <= 1'b1;
                            sclk_q <= 1'b1;
                        end else begin
                            hi_q   <= 1'b0;
                            sclk_q <= 1'b0;
                            if (bit_q == BW'(L - 1)) begin
                                sdata_q <= 1'b0;
                                sload_q <= 1'b1;
                                state_q <= LOAD;
                            end else begin
                                bit_q   <= bit_q + 1'b1;
                                sr_q    <= {sr_q[L-2:0], 1'b0};
                                sdata_q <= sr_q[L-2];
                            end
                        end
                    end
                end
                LOAD: begin
                    div_q <= div_q + 1'b1;
                    if (last_div) begin
                        div_q   <= '0;
                        sload_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                        for (int i = 0; i < N_CH; i++) begin
                            pd_q[i] <= frm_q[L-1-i*CW];
                            fc_q[i*FC_W +: FC_W] <= frm_q[L-2-i*CW -: FC_W];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
            // A new frame overrides the LOAD exit so busy stays high.
            if (go) begin
                state_q <= SHIFT;
                sr_q    <= snap;
                frm_q   <= snap;
                sdata_q <= snap[L-1];
                sclk_q  <= 1'b0;
                bit_q   <= '0;
                div_q   <= '0;
                hi_q    <= 1'b0;
                busy_q  <= 1'b1;
                pend_q  <= 1'b0;
            end else if (commit) begin
                pend_q  <= 1'b1;
            end
        end
    end

    assign ready = ready_q;
    assign rdata = rdata_q;
    assign busy  = busy_q;
    assign pd    = pd_q;
    assign fc    = fc_q;
    assign sclk  = sclk_q;
    assign sdata = sdata_q;
    assign sload = sload_q;

endmodule
